cond_unit: RTL
==============

// Module: cond_unit
// PURPOSE
//  Conditional-execution stage downstream of the multicycle control FSM and
//  the instruction decoder. Holds the architectural NZCV flags and evaluates
//  the instruction's 4-bit condition field against them. Gates the FSM/decoder
//  write strobes (RegW, MemW, PCS) into the final datapath enables.
//  It also owns flag updates from the ALU.
// PARAMETERS
//  FLAGS_RST   4'b0000  reset value of {N,Z,C,V}
// PORTS
//  clk        in   1  clock, all state updates on rising edge
//  reset      in   1  asynchronous, active-high; clears all state
//  Cond       in   4  instruction condition field Instr[31:28]
//  ALUFlags   in   4  ALU result flags {N,Z,C,V}, valid in execute cycles
//  FlagW      in   2  decoder flag-write request; [1]=N,Z  [0]=C,V
//  PCS        in   1  decoder: instruction writes PC (branch or Rd==R15)
//  NextPC     in   1  FSM: unconditional PC increment (fetch)
//  RegW       in   1  FSM register-file write strobe
//  MemW       in   1  FSM memory write strobe
//  PCWrite    out  1  PC register enable
//  RegWrite   out  1  register-file write enable
//  MemWrite   out  1  data-memory write enable
//  Flags      out  4  current architectural {N,Z,C,V}
//  CondEx     out  1  registered condition result (CondExDelayed)
// BEHAVIOUR
//  Reset (async): Flags=FLAGS_RST, CondEx=0. Therefore RegWrite=MemWrite=0
//   and PCWrite=NextPC until the first clock edge.
//  Combinational cond_ok from Cond and the registered Flags (not ALUFlags):
//   0000 EQ Z | 0001 NE !Z | 0010 CS C | 0011 CC !C | 0100 MI N | 0101 PL !N
//   0110 VS V | 0111 VC !V | 1000 HI C&!Z | 1001 LS !C|Z | 1010 GE N==V
//   1011 LT N!=V | 1100 GT !Z&(N==V) | 1101 LE Z|(N!=V) | 1110 AL 1
//   1111 NV 0 (reserved, never executes)
//  CondEx register: captures cond_ok on every rising edge (1-cycle delay).
//   The register is not gated. This lets the FSM's writeback states use the
//   result evaluated in the decode/execute cycle.
//  Flag write: FlagWrite[1:0] = FlagW & {2{cond_ok}} (undelayed cond_ok).
//   FlagWrite[1] loads N,Z from ALUFlags[3:2].
//   FlagWrite[0] loads C,V from ALUFlags[1:0].
//   Each pair is independent. An unwritten pair holds its value.
//   New flags are visible on Flags and in cond_ok the cycle after the edge.
//  Output gating (combinational):
//   RegWrite = RegW & CondEx
//   MemWrite = MemW & CondEx
//   PCWrite  = (PCS & CondEx) | NextPC
//  NextPC is never gated: fetch always advances the PC.
//  Simultaneous flag write and condition evaluation in one cycle: cond_ok
//   uses the pre-write flags. The write lands at the edge.
//  Reset mid-instruction: flags and CondEx clear immediately. Any pending
//   RegWrite/MemWrite deasserts in the same cycle (async).
//  X-safety: Cond X while strobes are low must not corrupt Flags.
//   FlagW=0 means no flag update, regardless of Cond.
// TESTING
//  1. Reset with FLAGS_RST=0 -> Flags=0000, CondEx=0, RegWrite=0.
//     Then NextPC=1 -> PCWrite=1.
//  2. FlagW=11, Cond=1110, ALUFlags=0100, edge -> Flags=0100.
//     Next cycle Cond=0000 (EQ): CondEx=1 after the edge.
//     RegW=1 -> RegWrite=1.
//  3. Flags=0100, Cond=0001 (NE), RegW=1, MemW=1 after the edge -> RegWrite=0,
//     MemWrite=0. PCS=1, NextPC=0 -> PCWrite=0.
//  4. Flags=1000, FlagW=01, ALUFlags=0011, Cond=AL -> Flags=1011 (N,Z held).
//     Then Cond=1010 (GE, N==V) -> CondEx=1. Cond=1011 (LT) -> CondEx=0.
//  5. Cond=1011 (LT) false with Flags=0000, FlagW=11, ALUFlags=1111 ->
//     Flags stay 0000 (a conditional flag write is suppressed).
//  6. Sweep all 16 Cond codes x 16 Flags values against a reference model.
//     Assert reset mid-sweep -> outputs match reset values within the cycle.

Source files
------------

// File: rtl/cond_unit.sv
// Conditional-execution unit: holds NZCV, evaluates Cond, gates write strobes.
// Ports: clk, reset, Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW ->
//        PCWrite, RegWrite, MemWrite, Flags, CondEx.
module cond_unit #(
   parameter logic [3:0] FLAGS_RST = 4'b0000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   input  logic [1:0] FlagW,
   input  logic       PCS,
   input  logic       NextPC,
   input  logic       RegW,
   input  logic       MemW,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic [3:0] Flags,
   output logic       CondEx
);

   logic [3:0] flags_q;
   logic       condex_q;
   logic       cond_ok;
   logic [1:0] flag_write;
   logic       n, z, c, v;

   assign {n, z, c, v} = flags_q;

   always_comb begin
      cond_ok = 1'b0;
      case (Cond)
         4'b0000: cond_ok = z;
         4'b0001: cond_ok = ~z;
         4'b0010: cond_ok = c;
         4'b0011: cond_ok = ~c;
         4'b0100: cond_ok = n;
         4'b0101: cond_ok = ~n;
         4'b0110: cond_ok = v;
         4'b0111: cond_ok = ~v;
         4'b1000: cond_ok = c & ~z;
         4'b1001: cond_ok = ~c | z;
         4'b1010: cond_ok = (n == v);
         4'b1011: cond_ok = (n != v);
         4'b1100: cond_ok = ~z & (n == v);
         4'b1101: cond_ok = z | (n != v);
         4'b1110: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

   // An idle FlagW forces zero regardless of an unknown Cond.
   assign flag_write = FlagW & {2{cond_ok}};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags_q  <= FLAGS_RST;
         condex_q <= 1'b0;
      end else begin
         condex_q <= cond_ok;
         if (flag_write[1]) flags_q[3:2] <= ALUFlags[3:2];
         if (flag_write[0]) flags_q[1:0] <= ALUFlags[1:0];
      end
   end

   assign RegWrite = RegW & condex_q;
   assign MemWrite = MemW & condex_q;
   assign PCWrite  = (PCS & condex_q) | NextPC;
   assign Flags    = flags_q;
   assign CondEx   = condex_q;

endmodule
